// File: rtl/fsm_step_pkg.sv
// fsm_step_pkg: shared types and default timing constants for the step sequencer
package fsm_step_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, STEP, CAPTURE} ctrl_state_t;
    localparam int FSM_STATE_W         = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_TICK_DIV        = 50_000_000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-level filter and rising-edge pulse for one button
module btn_debounce
    import fsm_step_pkg::*;
#(
    parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(CYCLES + 1);
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, rise_q, rise_d, settled;
    // accept the synchronised level once it has differed from the current one for CYCLES cycles
    always_comb begin
        sync_d  = {sync_q[0], raw};
        settled = (sync_q[1] != level_q) && (cnt_q == CW'(CYCLES - 1));
        cnt_d   = (sync_q[1] == level_q || settled) ? '0 : cnt_q + CW'(1);
        level_d = settled ? sync_q[1] : level_q;
        rise_d  = settled & sync_q[1];
    end
    // state registers, cleared by reset so no stale press survives it
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end
    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/fsm_step_ctrl.sv
// fsm_step_ctrl: steps/preloads the board FSM from buttons or an auto tick and records its outputs
module fsm_step_ctrl
    import fsm_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int HIST_W          = 8,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_step,
    input  logic                   btn_load,
    input  logic                   mode_auto,
    input  logic                   fsm_out,
    input  logic [FSM_STATE_W-1:0] fsm_state,
    output logic                   step_en,
    output logic                   fsm_load,
    output logic [HIST_W-1:0]      history,
    output logic [CNT_W-1:0]       step_count,
    output logic [FSM_STATE_W-1:0] last_state,
    output logic                   busy
);
    localparam int TW = $clog2(TICK_DIV);
    logic                   step_rise, load_rise, tick, step_req;
    logic [1:0]             mode_q, mode_d;
    logic [TW-1:0]          tick_q, tick_d;
    ctrl_state_t            state_q, state_d;
    logic [HIST_W-1:0]      hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FSM_STATE_W-1:0] last_q, last_d;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk(clk), .reset(reset), .raw(btn_step), .level(), .rise(step_rise)
    );
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk(clk), .reset(reset), .raw(btn_load), .level(), .rise(load_rise)
    );

    // mode sync, auto tick, sequencer transitions and capture; load wins over a same-cycle step
    always_comb begin
        mode_d   = {mode_q[0], mode_auto};
        tick     = mode_q[1] && (tick_q == TW'(TICK_DIV - 1));
        tick_d   = (!mode_q[1] || tick) ? '0 : tick_q + TW'(1);
        step_req = mode_q[1] ? tick : step_rise;
        state_d  = (state_q == IDLE) ? (load_rise ? LOAD : step_req ? STEP : IDLE)
                 : (state_q == STEP) ? CAPTURE : IDLE;
        hist_d   = (state_q == LOAD) ? '0
                 : (state_q == CAPTURE) ? {hist_q[HIST_W-2:0], fsm_out} : hist_q;
        cnt_d    = (state_q == LOAD) ? '0
                 : (state_q == CAPTURE && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        last_d   = (state_q == LOAD) ? '0 : (state_q == CAPTURE) ? fsm_state : last_q;
    end

    // registers; reset aborts any step or load in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= '0;
            tick_q  <= '0;
            state_q <= IDLE;
            hist_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign step_en    = (state_q == STEP);
    assign fsm_load   = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign history    = hist_q;
    assign step_count = cnt_q;
    assign last_state = last_q;
endmodule

// File: tb/tb_fsm_step_ctrl.sv
// tb_fsm_step_ctrl: directed checks of debounce, stepping, load priority, auto tick and saturation
module tb_fsm_step_ctrl;
    logic        clk = 1'b0;
    logic        reset, btn_step, btn_load, mode_auto, fsm_out;
    logic [2:0]  fsm_state;
    logic        step_en, fsm_load, busy, step_en2, fsm_load2, busy2;
    logic [7:0]  history, history2;
    logic [15:0] step_count;
    logic [1:0]  step_count2;
    logic [2:0]  last_state, last_state2;
    int checks = 0, errors = 0;
    int n_step = 0, n_load = 0, cyc = 0;
    logic prev_step = 1'b0, prev_load = 1'b0;

    always #5 clk = ~clk;

    fsm_step_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8), .HIST_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .btn_step(btn_step), .btn_load(btn_load),
        .mode_auto(mode_auto), .fsm_out(fsm_out), .fsm_state(fsm_state),
        .step_en(step_en), .fsm_load(fsm_load), .history(history),
        .step_count(step_count), .last_state(last_state), .busy(busy)
    );

    fsm_step_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8), .HIST_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .btn_step(btn_step), .btn_load(btn_load),
        .mode_auto(mode_auto), .fsm_out(fsm_out), .fsm_state(fsm_state),
        .step_en(step_en2), .fsm_load(fsm_load2), .history(history2),
        .step_count(step_count2), .last_state(last_state2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pulse counting plus exclusivity and width checks on every active pulse
    always @(negedge clk) begin
        cyc++;
        if (step_en || fsm_load) begin
            chk("excl", {31'b0, step_en & fsm_load}, 0);
            chk("width", {31'b0, (step_en & prev_step) | (fsm_load & prev_load)}, 0);
        end
        n_step += int'(step_en);
        n_load += int'(fsm_load);
        prev_step = step_en;
        prev_load = fsm_load;
    end

    task automatic press_step();
        btn_step = 1'b1;
        repeat (12) @(negedge clk);
        btn_step = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_step(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (step_en) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("step_timeout", 1, 0);
    endtask

    initial begin
        int s0, l0, t, tprev;
        logic [2:0] exp2;
        reset = 1'b1; btn_step = 1'b0; btn_load = 1'b0; mode_auto = 1'b0;
        fsm_out = 1'b0; fsm_state = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_hist", {24'b0, history}, 0);
        chk("rst_cnt", {16'b0, step_count}, 0);
        chk("rst_last", {29'b0, last_state}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_pulses", {30'b0, step_en, fsm_load}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // bouncy press then long hold: one step
        fsm_out = 1'b1; fsm_state = 3'd5; s0 = n_step;
        btn_step = 1'b1; @(negedge clk);
        btn_step = 1'b0; @(negedge clk);
        btn_step = 1'b1; @(negedge clk);
        repeat (10) @(negedge clk);
        btn_step = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_pulses", n_step - s0, 1);
        chk("bounce_hist", {24'b0, history}, 8'h01);
        chk("bounce_cnt", {16'b0, step_count}, 1);
        chk("bounce_last", {29'b0, last_state}, 5);

        // reset held 3 cycles while in STEP
        btn_step = 1'b1;
        wait_step(t);
        reset = 1'b1; btn_step = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_hist", {24'b0, history}, 0);
        chk("midrst_cnt", {16'b0, step_count}, 0);
        chk("midrst_last", {29'b0, last_state}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        reset = 1'b0; s0 = n_step;
        repeat (15) @(negedge clk);
        chk("midrst_nostep", n_step - s0, 0);
        chk("midrst_cnt2", {16'b0, step_count}, 0);

        // 9 steps of fsm_out=1: saturation on the 2-bit counter, history fills
        for (int i = 1; i <= 9; i++) begin
            fsm_state = 3'(i);
            press_step();
            exp2 = (i > 3) ? 3'd3 : 3'(i);
            if (i <= 5) chk($sformatf("sat_cnt2_%0d", i), {30'b0, step_count2}, {29'b0, exp2});
            if (i == 3) chk("hist_3", {24'b0, history}, 8'h07);
        end
        chk("hist_9", {24'b0, history}, 8'hFF);
        chk("cnt_9", {16'b0, step_count}, 9);
        chk("last_9", {29'b0, last_state}, 3'(9));

        // load and step accepted in the same cycle: load only
        s0 = n_step; l0 = n_load;
        btn_load = 1'b1; btn_step = 1'b1;
        repeat (12) @(negedge clk);
        btn_load = 1'b0; btn_step = 1'b0;
        repeat (10) @(negedge clk);
        chk("both_load", n_load - l0, 1);
        chk("both_step", n_step - s0, 0);
        chk("both_hist", {24'b0, history}, 0);
        chk("both_cnt", {16'b0, step_count}, 0);
        chk("both_last", {29'b0, last_state}, 0);

        // auto mode: 5 ticks with fsm_out 1,0,1,0,1
        tprev = -1;
        fsm_out = 1'b1; fsm_state = 3'd0;
        mode_auto = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_step(t);
            if (tprev >= 0) chk($sformatf("tick_gap_%0d", i), t - tprev, 8);
            tprev = t;
            repeat (2) @(negedge clk);
            if (i == 4) mode_auto = 1'b0;
            fsm_out = ~fsm_out; fsm_state = 3'(i + 1);
        end
        s0 = n_step;
        repeat (20) @(negedge clk);
        chk("auto_stop", n_step - s0, 0);
        chk("auto_hist", {24'b0, history}, 8'h15);
        chk("auto_cnt", {16'b0, step_count}, 5);
        chk("auto_cnt2", {30'b0, step_count2}, 3);
        chk("auto_last", {29'b0, last_state}, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
